baby_store: RTL and testbench

Main-store responder for the `manchester_baby` CPU: a 32-word × 32-bit memory that services the CPU's `ram_addr_o` / `ram_data_o` / `ram_rw_en_o` / `ram_data_i` port. It adds a host-side loader port for preloading and reading back programs, a sequenced clear engine, and a run/hold controller that keeps the CPU in reset while the store is being loaded or cleared. It sits beside the CPU at the top level, replacing the bench-side RAM model.

---
 rtl/baby_store_if.sv | 35 +++
 rtl/baby_store.sv | 105 ++++++++++
 tb/tb_baby_store.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/baby_store_if.sv
// Bundles the CPU memory port, host loader port and run/clear controls of the main store.
// The slave modport is the store; the master modport is the CPU/host side driving it.
interface baby_store_if;
   logic [4:0]  cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_rw_en_i;
   logic [31:0] cpu_data_o;
   logic        cpu_hold_o;
   logic        ld_valid_i;
   logic        ld_ready_o;
   logic [4:0]  ld_addr_i;
   logic [31:0] ld_data_i;
   logic [31:0] ld_rdata_o;
   logic        clear_i;
   logic        run_i;
   logic        busy_o;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_rw_en_i,
      output cpu_data_o, cpu_hold_o,
      input  ld_valid_i, ld_addr_i, ld_data_i,
      output ld_ready_o, ld_rdata_o,
      input  clear_i, run_i,
      output busy_o
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_rw_en_i,
      input  cpu_data_o, cpu_hold_o,
      output ld_valid_i, ld_addr_i, ld_data_i,
      input  ld_ready_o, ld_rdata_o,
      output clear_i, run_i,
      input  busy_o
   );
endinterface

// File: rtl/baby_store.sv
// 32x32 main store for the Baby CPU with host loader, sequenced clear and CPU run/hold control.
// Reads are combinational on both ports; one write source per cycle is chosen by the FSM state.
module baby_store (
   input  logic         clock,
   input  logic         reset_n_i,
   baby_store_if.slave  bus
);

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mem_q [32];

   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        hold, ready, busy;

   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_HOLD;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_HOLD: begin
            if (bus.clear_i) begin
               state_d = S_CLEAR;
               cnt_d   = 5'd0;
            end else if (bus.run_i) begin
               state_d = S_RUN;
            end
         end
         S_CLEAR: begin
            // Counter wraps to 0 naturally after word 31, ready for the next clear.
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_HOLD;
            end
         end
         S_RUN: begin
            if (!bus.run_i) begin
               state_d = S_HOLD;
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   always_comb begin
      hold      = 1'b1;
      ready     = 1'b0;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.ld_addr_i;
      mem_wdata = bus.ld_data_i;
      case (state_q)
         S_HOLD: begin
            ready  = 1'b1;
            mem_we = bus.ld_valid_i;
         end
         S_CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = 32'd0;
         end
         S_RUN: begin
            hold      = 1'b0;
            mem_we    = bus.cpu_rw_en_i;
            mem_waddr = bus.cpu_addr_i;
            mem_wdata = bus.cpu_data_i;
         end
         default: begin
            hold = 1'b1;
         end
      endcase
   end

   // Storage is deliberately not reset so an aborted clear leaves untouched words intact.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.cpu_data_o = mem_q[bus.cpu_addr_i];
   assign bus.ld_rdata_o = mem_q[bus.ld_addr_i];
   assign bus.cpu_hold_o = hold;
   assign bus.ld_ready_o = ready;
   assign bus.busy_o     = busy;

endmodule

// File: tb/tb_baby_store.sv
// Directed self-checking bench for baby_store: clear, load/readback, hold gating, RUN writes, resets.
module tb_baby_store;

   logic clock;
   logic reset_n_i;
   int   n_checks;
   int   n_fail;

   baby_store_if bus ();

   baby_store dut (
      .clock     (clock),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      bus.cpu_addr_i = 5'd0; bus.cpu_data_i = 32'd0; bus.cpu_rw_en_i = 1'b0;
      bus.ld_valid_i = 1'b0; bus.ld_addr_i = 5'd0; bus.ld_data_i = 32'd0;
      bus.clear_i = 1'b0; bus.run_i = 1'b0;
      step(); step();
      #1;
      n_checks++;
      if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b exp 1", bus.cpu_hold_o); end
      n_checks++;
      if (bus.ld_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.ld_ready_o); end
      n_checks++;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
      reset_n_i = 1'b1;
      step();
      $display("reset: hold=%b ready=%b busy=%b", bus.cpu_hold_o, bus.ld_ready_o, bus.busy_o);
   endtask

   task automatic test_reset_then_clear();
      int busy_cnt;
      bus.clear_i = 1'b1;
      step();
      bus.clear_i = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.busy_o !== 1'b1) break;
         busy_cnt++;
         step();
      end
      n_checks++;
      if (busy_cnt != 32) begin n_fail++; $display("FAIL clear_busy_cycles got %0d exp 32", busy_cnt); end
      n_checks++;
      if (bus.ld_ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_ready_after got %b exp 1", bus.ld_ready_o); end
      for (int a = 0; a < 32; a++) begin
         bus.ld_addr_i = 5'(a);
         #1;
         n_checks++;
         if (bus.ld_rdata_o !== 32'd0) begin n_fail++; $display("FAIL clear_word[%0d] got %h exp 00000000", a, bus.ld_rdata_o); end
      end
      $display("clear: busy for %0d cycles, ready=%b", busy_cnt, bus.ld_ready_o);
   endtask

   task automatic load_all(input logic [31:0] base, input bit add_addr);
      for (int a = 0; a < 32; a++) begin
         bus.ld_valid_i = 1'b1;
         bus.ld_addr_i  = 5'(a);
         bus.ld_data_i  = add_addr ? base + 32'(a) : base;
         step();
      end
      bus.ld_valid_i = 1'b0;
   endtask

   task automatic test_load();
      load_all(32'hDEAD_0000, 1'b1);
      for (int a = 0; a < 32; a++) begin
         bus.ld_addr_i  = 5'(a);
         bus.cpu_addr_i = 5'(a);
         #1;
         n_checks++;
         if (bus.ld_rdata_o !== 32'hDEAD_0000 + 32'(a)) begin
            n_fail++; $display("FAIL load_ld_rdata[%0d] got %h exp %h", a, bus.ld_rdata_o, 32'hDEAD_0000 + 32'(a));
         end
         n_checks++;
         if (bus.cpu_data_o !== 32'hDEAD_0000 + 32'(a)) begin
            n_fail++; $display("FAIL load_cpu_data[%0d] got %h exp %h", a, bus.cpu_data_o, 32'hDEAD_0000 + 32'(a));
         end
      end
      $display("load: 32 words written and read back on both ports");
   endtask

   task automatic test_hold_blocks_cpu();
      bus.cpu_rw_en_i = 1'b1; bus.cpu_addr_i = 5'd5; bus.cpu_data_i = 32'h1234_5678;
      step();
      bus.cpu_rw_en_i = 1'b0;
      bus.ld_addr_i = 5'd5;
      #1;
      n_checks++;
      if (bus.ld_rdata_o !== 32'hDEAD_0005) begin n_fail++; $display("FAIL hold_blocks_write got %h exp dead0005", bus.ld_rdata_o); end
      bus.run_i = 1'b1;
      #1;
      n_checks++;
      if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL hold_before_edge got %b exp 1", bus.cpu_hold_o); end
      step();
      n_checks++;
      if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("FAIL run_hold got %b exp 0", bus.cpu_hold_o); end
      n_checks++;
      if (bus.ld_ready_o !== 1'b0) begin n_fail++; $display("FAIL run_ready got %b exp 0", bus.ld_ready_o); end
      bus.cpu_rw_en_i = 1'b1;
      step();
      bus.cpu_rw_en_i = 1'b0;
      #1;
      n_checks++;
      if (bus.ld_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL run_cpu_write got %h exp 12345678", bus.ld_rdata_o); end
      $display("hold_blocks_cpu: mem[5]=%h hold=%b", bus.ld_rdata_o, bus.cpu_hold_o);
   endtask

   task automatic test_same_cycle_rw();
      bus.cpu_addr_i = 5'd31; bus.cpu_data_i = 32'hFFFF_FFFF; bus.cpu_rw_en_i = 1'b1;
      #1;
      n_checks++;
      if (bus.cpu_data_o !== 32'hDEAD_001F) begin n_fail++; $display("FAIL rw_old_word got %h exp dead001f", bus.cpu_data_o); end
      step();
      bus.cpu_rw_en_i = 1'b0;
      #1;
      n_checks++;
      if (bus.cpu_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rw_new_word got %h exp ffffffff", bus.cpu_data_o); end
      // Dropping run with a CPU write in the same cycle: the write must still land.
      bus.run_i = 1'b0; bus.cpu_rw_en_i = 1'b1; bus.cpu_addr_i = 5'd7; bus.cpu_data_i = 32'h0000_7777;
      step();
      bus.cpu_rw_en_i = 1'b0; bus.ld_addr_i = 5'd7;
      #1;
      n_checks++;
      if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL run_drop_hold got %b exp 1", bus.cpu_hold_o); end
      n_checks++;
      if (bus.ld_rdata_o !== 32'h0000_7777) begin n_fail++; $display("FAIL run_drop_write got %h exp 00007777", bus.ld_rdata_o); end
      $display("same_cycle_rw: mem[31]=%h mem[7]=%h", bus.cpu_data_o, bus.ld_rdata_o);
   endtask

   task automatic test_simultaneous();
      bus.ld_valid_i = 1'b1; bus.ld_addr_i = 5'd3; bus.ld_data_i = 32'h0000_00AA;
      bus.clear_i = 1'b1; bus.run_i = 1'b1;
      step();
      bus.ld_valid_i = 1'b0; bus.clear_i = 1'b0;
      #1;
      n_checks++;
      if (bus.ld_rdata_o !== 32'h0000_00AA) begin n_fail++; $display("FAIL simul_load_done got %h exp 000000aa", bus.ld_rdata_o); end
      n_checks++;
      if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL simul_clear_first got %b exp 1", bus.busy_o); end
      repeat (31) step();
      n_checks++;
      if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL simul_busy_32nd got %b exp 1", bus.busy_o); end
      step();
      n_checks++;
      if (bus.busy_o !== 1'b0 || bus.cpu_hold_o !== 1'b1 || bus.ld_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL simul_back_to_hold got busy=%b hold=%b ready=%b exp 0 1 1", bus.busy_o, bus.cpu_hold_o, bus.ld_ready_o);
      end
      n_checks++;
      if (bus.ld_rdata_o !== 32'd0) begin n_fail++; $display("FAIL simul_word3_cleared got %h exp 00000000", bus.ld_rdata_o); end
      step();
      n_checks++;
      if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("FAIL simul_then_run got %b exp 0", bus.cpu_hold_o); end
      $display("simultaneous: word3=%h hold=%b", bus.ld_rdata_o, bus.cpu_hold_o);
   endtask

   task automatic test_reset_mid_run();
      #2;
      reset_n_i = 1'b0;
      #1;
      n_checks++;
      if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL async_hold_run got %b exp 1", bus.cpu_hold_o); end
      bus.run_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      step();
      $display("reset_mid_run: hold=%b", bus.cpu_hold_o);
   endtask

   task automatic test_reset_mid_clear();
      load_all(32'h5555_5555, 1'b0);
      bus.clear_i = 1'b1;
      step();
      bus.clear_i = 1'b0;
      repeat (9) step();
      #2;
      reset_n_i = 1'b0;
      #1;
      n_checks++;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy_o); end
      n_checks++;
      if (bus.cpu_hold_o !== 1'b1 || bus.ld_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL abort_hold_ready got hold=%b ready=%b exp 1 1", bus.cpu_hold_o, bus.ld_ready_o);
      end
      reset_n_i = 1'b1;
      for (int a = 0; a < 32; a++) begin
         if (a != 9) begin
            bus.ld_addr_i = 5'(a);
            #1;
            n_checks++;
            if (bus.ld_rdata_o !== ((a < 9) ? 32'd0 : 32'h5555_5555)) begin
               n_fail++; $display("FAIL abort_word[%0d] got %h exp %h", a, bus.ld_rdata_o, (a < 9) ? 32'd0 : 32'h5555_5555);
            end
         end
      end
      $display("reset_mid_clear: busy=%b hold=%b", bus.busy_o, bus.cpu_hold_o);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_reset_then_clear();
      test_load();
      test_hold_blocks_cpu();
      test_same_cycle_rw();
      test_simultaneous();
      test_reset_mid_run();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
